rom_loader: RTL

//  Byte-stream writer for the 32K x 16 Hack instruction memory. Parses a framed

---
 rtl/rom_loader_pkg.sv | 23 ++
 rtl/rom_loader_timeout.sv | 29 ++
 rtl/rom_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the framed program-image loader.
// States, error codes and defaults used by rom_loader and its bench.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CSUM,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         DEPTH_DEFAULT     = 32768;

endpackage

// File: rtl/rom_loader_timeout.sv
// Inter-byte idle counter: cleared by clr, counts while en, and flags
// expire once TIMEOUT_CYC idle clocks have accumulated.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int             W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0]   LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clr || !en)
      cnt <= '0;
    else if (cnt != LIMIT)
      cnt <= cnt + W'(1);
  end

  assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/rom_loader.sv
// Parses SYNC/LEN/DATA/CSUM byte frames into 16-bit instruction-memory writes,
// holding the CPU in reset while a load is in progress or has failed.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         DEPTH       = DEPTH_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state, state_d;
  logic [7:0]  sum;
  logic [7:0]  len_hi;
  logic [7:0]  hi_q;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] widx;
  logic        tmo_expire;
  logic        take_sync;
  logic        acc_byte;
  logic        wr_word;
  logic        load_ok;
  logic        err_set;
  logic [1:0]  err_val;

  assign len_in   = {len_hi, rx_data};
  assign busy     = !(state == S_IDLE || state == S_ERR);
  assign acc_byte = rx_valid && (state == S_LEN_HI || state == S_LEN_LO ||
                                 state == S_DAT_HI || state == S_DAT_LO);

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clr    (rx_valid),
    .en     (busy),
    .expire (tmo_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state;
    take_sync = 1'b0;
    wr_word   = 1'b0;
    load_ok   = 1'b0;
    err_set   = 1'b0;
    err_val   = ERR_NONE;
    case (state)
      S_IDLE, S_ERR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d   = S_LEN_HI;
          take_sync = 1'b1;
        end
      end
      S_LEN_HI: if (rx_valid) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (rx_valid) begin
          if ({1'b0, len_in} > DEPTH_L) begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = ERR_LEN;
          end else if (len_in == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DAT_HI;
          end
        end
      end
      S_DAT_HI: if (rx_valid) state_d = S_DAT_LO;
      S_DAT_LO: begin
        if (rx_valid) begin
          wr_word = 1'b1;
          state_d = (widx + 16'd1 == len) ? S_CSUM : S_DAT_HI;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum) begin
            state_d = S_IDLE;
            load_ok = 1'b1;
          end else begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A byte arriving in the expiry cycle is consumed instead of timing out.
    if (tmo_expire && !rx_valid) begin
      state_d = S_ERR;
      err_set = 1'b1;
      err_val = ERR_TMO;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_reset <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_NONE;
      sum       <= '0;
      len_hi    <= '0;
      hi_q      <= '0;
      len       <= '0;
      widx      <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;

      if (take_sync) begin
        sum       <= '0;
        widx      <= '0;
        mem_addr  <= '0;
        err_code  <= ERR_NONE;
        cpu_reset <= 1'b1;
      end else if (acc_byte) begin
        sum <= sum + rx_data;
      end

      if (rx_valid && state == S_LEN_HI) len_hi <= rx_data;
      if (rx_valid && state == S_LEN_LO) len    <= len_in;
      if (rx_valid && state == S_DAT_HI) hi_q   <= rx_data;

      if (wr_word) begin
        mem_we   <= 1'b1;
        mem_data <= {hi_q, rx_data};
        mem_addr <= widx[14:0];
        widx     <= widx + 16'd1;
      end

      if (load_ok) begin
        done      <= 1'b1;
        cpu_reset <= 1'b0;
      end

      if (err_set) err_code <= err_val;
    end
  end

endmodule
